// File: rtl/sump_cmd_decoder.sv
// sump_cmd_decoder: frames 5-byte SUMP commands from the UART byte stream into
// control pulses and capture configuration registers, with inter-byte timeout.
module sump_cmd_decoder #(
  parameter int SAMPLE_WIDTH   = 8,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    system_clock,
  input  logic                    ext_reset_n,
  input  logic [7:0]              rx_data,
  input  logic                    rx_valid,
  input  logic                    capture_active,
  output logic                    cmd_reset,
  output logic                    cmd_arm,
  output logic                    cmd_query_meta,
  output logic                    cmd_query_id,
  output logic                    cfg_update,
  output logic                    cmd_error,
  output logic [23:0]             sample_div,
  output logic [15:0]             read_count,
  output logic [15:0]             delay_count,
  output logic [SAMPLE_WIDTH-1:0] trig_rising,
  output logic [SAMPLE_WIDTH-1:0] trig_falling
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic {IDLE, COLLECT} state_t;
  state_t          r_state;
  logic [2:0]      r_idx;
  logic [CW-1:0]   r_cnt;
  logic [3:0][7:0] r_b;
  always_ff @(posedge system_clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      r_state        <= IDLE;
      r_idx          <= '0;
      r_cnt          <= '0;
      r_b            <= '0;
      cmd_reset      <= 1'b0;
      cmd_arm        <= 1'b0;
      cmd_query_meta <= 1'b0;
      cmd_query_id   <= 1'b0;
      cfg_update     <= 1'b0;
      cmd_error      <= 1'b0;
      sample_div     <= '0;
      read_count     <= '0;
      delay_count    <= '0;
      trig_rising    <= '0;
      trig_falling   <= '0;
    end else begin
      cmd_reset      <= 1'b0;
      cmd_arm        <= 1'b0;
      cmd_query_meta <= 1'b0;
      cmd_query_id   <= 1'b0;
      cfg_update     <= 1'b0;
      cmd_error      <= 1'b0;
      case (r_state)
        IDLE: if (rx_valid) begin
          r_b[0]  <= rx_data;
          r_idx   <= 3'd1;
          r_cnt   <= '0;
          r_state <= COLLECT;
        end
        COLLECT: if (rx_valid) begin
          r_cnt <= '0;
          if (r_idx == 3'd4) begin
            // B4 is consumed straight from rx_data; B0..B3 are already held
            r_state <= IDLE;
            r_idx   <= '0;
            case (r_b[0])
              8'h00: cmd_reset <= 1'b1;
              8'h01: if (capture_active) cmd_error <= 1'b1; else cmd_arm <= 1'b1;
              8'h02: cmd_query_meta <= 1'b1;
              8'h04: cmd_query_id <= 1'b1;
              8'h80: if (capture_active) cmd_error <= 1'b1; else begin
                cfg_update <= 1'b1;
                sample_div <= {r_b[2], r_b[3], rx_data};
              end
              8'h81: if (capture_active) cmd_error <= 1'b1; else begin
                cfg_update  <= 1'b1;
                read_count  <= {r_b[1], r_b[2]};
                delay_count <= {r_b[3], rx_data};
              end
              8'hC1: if (capture_active) cmd_error <= 1'b1; else begin
                cfg_update   <= 1'b1;
                trig_falling <= r_b[3][SAMPLE_WIDTH-1:0];
                trig_rising  <= rx_data[SAMPLE_WIDTH-1:0];
              end
              default: cmd_error <= 1'b1;
            endcase
          end else begin
            r_b[r_idx[1:0]] <= rx_data;
            r_idx           <= r_idx + 3'd1;
          end
        end else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
          cmd_error <= 1'b1;
          r_state   <= IDLE;
          r_idx     <= '0;
          r_cnt     <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sump_cmd_decoder.sv
// tb_sump_cmd_decoder: directed frames against a queue-based command model,
// checked every cycle, plus hand-computed literal expectations.
module tb_sump_cmd_decoder;
  localparam int T = 20;
  logic clk = 1'b0;
  logic ext_reset_n = 1'b0;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic capture_active = 1'b0;
  logic cmd_reset, cmd_arm, cmd_query_meta, cmd_query_id, cfg_update, cmd_error;
  logic [23:0] sample_div;
  logic [15:0] read_count, delay_count;
  logic [7:0] trig_rising, trig_falling;
  int checks = 0;
  int errors = 0;
  int n[6] = '{default: 0};
  bit run = 1'b0;

  sump_cmd_decoder #(.SAMPLE_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .system_clock(clk), .ext_reset_n(ext_reset_n), .rx_data(rx_data),
    .rx_valid(rx_valid), .capture_active(capture_active),
    .cmd_reset(cmd_reset), .cmd_arm(cmd_arm), .cmd_query_meta(cmd_query_meta),
    .cmd_query_id(cmd_query_id), .cfg_update(cfg_update), .cmd_error(cmd_error),
    .sample_div(sample_div), .read_count(read_count), .delay_count(delay_count),
    .trig_rising(trig_rising), .trig_falling(trig_falling));

  always #5 clk = ~clk;

  // pulse vector order: reset, arm, meta, id, cfg, err
  logic [5:0] e_p = '0;
  logic [23:0] e_div = '0;
  logic [15:0] e_rc = '0, e_dc = '0;
  logic [7:0] e_tr = '0, e_tf = '0;
  logic [7:0] frame[$];
  int idle = 0;

  always @(posedge clk or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      frame = {}; idle = 0; e_p = '0;
      e_div = '0; e_rc = '0; e_dc = '0; e_tr = '0; e_tf = '0;
    end else begin
      e_p = '0;
      if (rx_valid) begin
        frame.push_back(rx_data);
        idle = 0;
        if (frame.size() == 5) begin
          case (frame[0])
            8'h00: e_p[5] = 1'b1;
            8'h01: if (capture_active) e_p[0] = 1'b1; else e_p[4] = 1'b1;
            8'h02: e_p[3] = 1'b1;
            8'h04: e_p[2] = 1'b1;
            8'h80, 8'h81, 8'hC1:
              if (capture_active) e_p[0] = 1'b1;
              else begin
                e_p[1] = 1'b1;
                if (frame[0] == 8'h80) e_div = {frame[2], frame[3], frame[4]};
                if (frame[0] == 8'h81) begin e_rc = {frame[1], frame[2]}; e_dc = {frame[3], frame[4]}; end
                if (frame[0] == 8'hC1) begin e_tf = frame[3]; e_tr = frame[4]; end
              end
            default: e_p[0] = 1'b1;
          endcase
          frame = {};
        end
      end else if (frame.size() != 0) begin
        if (idle == T) begin e_p[0] = 1'b1; frame = {}; idle = 0; end
        else idle++;
      end
    end
  end

  wire [5:0] w_p = {cmd_reset, cmd_arm, cmd_query_meta, cmd_query_id, cfg_update, cmd_error};

  always @(negedge clk) if (run) begin
    checks++;
    if ({w_p, sample_div, read_count, delay_count, trig_rising, trig_falling} !==
        {e_p, e_div, e_rc, e_dc, e_tr, e_tf}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t dut p=%b div=%h rc=%h dc=%h tr=%h tf=%h model p=%b div=%h rc=%h dc=%h tr=%h tf=%h",
               $time, w_p, sample_div, read_count, delay_count, trig_rising, trig_falling,
               e_p, e_div, e_rc, e_dc, e_tr, e_tf);
    end
    checks++;
    if ($countones(w_p) > 1) begin
      errors++;
      $display("FAIL one_pulse t=%0t pulses=%b required at most one set", $time, w_p);
    end
    for (int i = 0; i < 6; i++) n[i] += int'(w_p[i]);
  end

  task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send(logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_cycles(int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(logic [7:0] b0, b1, b2, b3, b4);
    send(b0); send(b1); send(b2); send(b3); send(b4);
    wait_cycles(2);
  endtask

  function automatic int total();
    return n[0] + n[1] + n[2] + n[3] + n[4] + n[5];
  endfunction

  int snap;

  initial begin
    @(posedge clk); #1;
    run = 1'b1;
    chk("reset_outputs", {w_p, sample_div, read_count, delay_count, trig_rising, trig_falling}, '0);
    wait_cycles(1);
    ext_reset_n = 1'b1;
    wait_cycles(2);

    send_frame(8'h00, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("reset_pulse", n[5], 1);
    chk("only_reset_pulse", total(), 1);

    send_frame(8'h81, 8'h3E, 8'h80, 8'h00, 8'hFF);
    chk("read_count", read_count, 16'h3E80);
    chk("delay_count", delay_count, 16'h00FF);
    chk("cfg_pulse", n[1], 1);
    send_frame(8'h80, 8'h00, 8'h12, 8'h34, 8'h56);
    chk("sample_div", sample_div, 24'h123456);

    send_frame(8'hC1, 8'h00, 8'h00, 8'h0F, 8'hF0);
    chk("trig_falling", trig_falling, 8'h0F);
    chk("trig_rising", trig_rising, 8'hF0);
    capture_active = 1'b1;
    send_frame(8'hC1, 8'h00, 8'h00, 8'hAA, 8'h55);
    capture_active = 1'b0;
    chk("locked_err", n[0], 1);
    chk("locked_trig", {trig_falling, trig_rising}, 16'h0FF0);
    chk("locked_no_cfg", n[1], 3);

    send_frame(8'h04, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00, 8'h00);
    send_frame(8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("id_meta_arm", {n[2], n[3], n[4]}, {32'd1, 32'd1, 32'd1});
    send_frame(8'h33, 8'h00, 8'h00, 8'h00, 8'h00);
    chk("unknown_err", n[0], 2);
    chk("unknown_total", total(), 9);

    send(8'h81); send(8'h3E);
    wait_cycles(T + 3);
    chk("timeout_err", n[0], 3);
    chk("timeout_rc", read_count, 16'h3E80);
    send_frame(8'h81, 8'h00, 8'h10, 8'h00, 8'h20);
    chk("post_timeout_rc", read_count, 16'h0010);
    chk("post_timeout_dc", delay_count, 16'h0020);

    // third byte lands on the cycle the timeout would fire
    send(8'h81); send(8'h3E);
    wait_cycles(T);
    send(8'h00); send(8'h40); send(8'h00);
    wait_cycles(2);
    chk("edge_no_err", n[0], 3);
    chk("edge_rc", read_count, 16'h3E00);
    chk("edge_dc", delay_count, 16'h4000);

    send(8'h80); send(8'h00); send(8'h00);
    ext_reset_n = 1'b0;
    #1;
    chk("midframe_reset", {w_p, sample_div, read_count, delay_count, trig_rising, trig_falling}, '0);
    @(posedge clk); #1;
    ext_reset_n = 1'b1;
    snap = total();
    send(8'h01);
    wait_cycles(3);
    chk("no_pulse_after_reset", total(), snap);
    wait_cycles(T + 3);
    chk("stray_byte_timeout", n[0], 4);
    send_frame(8'h80, 8'h00, 8'h00, 8'h00, 8'h07);
    chk("sample_div_after_reset", sample_div, 24'h000007);

    run = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sump_cmd_decoder.md
# sump_cmd_decoder

Frames the UART receive byte stream into 5-byte SUMP-style commands and turns them into control pulses and configuration registers for the capture datapath. It sits between the UART receiver and the capture, trigger and metadata blocks inside the analyzer top level. An inter-byte timeout resynchronises framing. Configuration writes are locked out while a capture is in progress.

## Interface
- SAMPLE_WIDTH, 8: probe count, legal range 1–8; sets trigger register width.
- TIMEOUT_CYCLES, 100000: idle cycles mid-frame before the partial frame is discarded (1 ms at 100 MHz); must be ≥ 2.

Ports:
- system_clock  in  1  sole clock.
- ext_reset_n  in  1  asynchronous, active-low reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid.
- capture_active  in  1  high while capture is armed or running.
- cmd_reset  out  1  one-cycle pulse, opcode 0x00.
- cmd_arm  out  1  one-cycle pulse, opcode 0x01.
- cmd_query_meta  out  1  one-cycle pulse, opcode 0x02.
- cmd_query_id  out  1  one-cycle pulse, opcode 0x04.
- cfg_update  out  1  one-cycle pulse, a config register was written.
- cmd_error  out  1  one-cycle pulse: unknown opcode, locked-out command or timeout.
- sample_div  out  24  sample-rate divider.
- read_count  out  16  samples to read back.
- delay_count  out  16  post-trigger sample count.
- trig_rising  out  SAMPLE_WIDTH  rising-edge trigger mask.
- trig_falling  out  SAMPLE_WIDTH  falling-edge trigger mask.

## Operation
- Every command is exactly 5 bytes: opcode B0, then payload B1..B4, big-endian. Unused payload bytes are still consumed.
- States:
  - IDLE: rx_valid stores B0 and moves to COLLECT with idx=1.
  - COLLECT: each rx_valid stores B[idx] and increments idx.
  - The byte with idx=4 completes the frame: the command executes and the state returns to IDLE.
- Execution on frame completion:
  - 0x00 → cmd_reset. Always honoured; config registers are not cleared.
  - 0x01 → cmd_arm. If capture_active is high, cmd_error is pulsed instead.
  - 0x02 → cmd_query_meta.
  - 0x04 → cmd_query_id.
  - 0x80 → sample_div = {B2,B3,B4}; B1 is ignored.
  - 0x81 → read_count = {B1,B2}, delay_count = {B3,B4}.
  - 0xC1 → trig_falling = B3[SAMPLE_WIDTH-1:0], trig_rising = B4[SAMPLE_WIDTH-1:0]; B1 and B2 are ignored.
  - Any other opcode → cmd_error; no register changes.
- 0x80, 0x81 and 0xC1 write registers and pulse cfg_update only if capture_active is low at frame completion. Otherwise they pulse cmd_error and leave all registers unchanged.
- Timeout:
  - In COLLECT, a counter is cleared on each accepted byte and increments every cycle without rx_valid.
  - When the counter reaches TIMEOUT_CYCLES, the partial frame is dropped, cmd_error is pulsed and the state returns to IDLE.
  - If rx_valid arrives in the same cycle the timeout would fire, the byte wins: it is accepted and no error is raised.
- At most one output pulse is asserted per cycle.

## Timing
- Reset values: state IDLE, idx 0, timeout counter 0, all pulses 0, all config registers 0.
- Latency: when frame byte 5 is strobed in cycle N, registers update and the pulse is asserted in cycle N+1, for exactly one cycle.
- Back-to-back rx_valid on consecutive cycles is accepted. The next frame's B0 may arrive in cycle N+1.
- capture_active is sampled in the completion cycle N.
- Reset asserted mid-frame: the frame is discarded immediately, all outputs return to their reset values, and there is no pulse on deassertion.
- The timeout pulse asserts in the cycle after the counter reaches TIMEOUT_CYCLES.

## Test plan
- Frame 00 00 00 00 00 after reset → exactly one cmd_reset pulse, one cycle after the fifth byte; no other pulses.
- Frame 81 3E 80 00 FF → read_count=0x3E80, delay_count=0x00FF, one cfg_update pulse. Then frame 80 00 12 34 56 → sample_div=0x123456.
- Frame C1 00 00 0F F0 → trig_falling=0x0F, trig_rising=0xF0. Repeat with capture_active=1 and payload 00 00 AA 55 → cmd_error, registers still 0x0F/0xF0.
- Frames 04 00 00 00 00, then 02 00 00 00 00, then 01 00 00 00 00 → pulses cmd_query_id, cmd_query_meta, cmd_arm in order, one each. A frame 33 00 00 00 00 → cmd_error only.
- Timeout:
  - Send 81 3E, then idle for TIMEOUT_CYCLES → cmd_error, read_count unchanged.
  - A following full frame 81 00 10 00 20 decodes correctly: read_count=0x0010, delay_count=0x0020.
  - Re-run with the third byte landing on the exact timeout cycle → no error.
- Assert ext_reset_n low after 3 bytes of frame 80 00 00 01 → all outputs zero. Deassert and send a full frame 80 00 00 00 07 → sample_div=0x000007.
